// File: rtl/sample_capture_ctrl_pkg.sv
// Shared definitions for the sample capture controller: default widths and
// FSM state encodings.
package sample_capture_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 10;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRETRIG   = 3'd1;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
    localparam logic [2:0] ST_POSTTRIG  = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    function automatic logic is_run_state(input logic [2:0] st);
        return (st == ST_PRETRIG) || (st == ST_WAIT_TRIG) || (st == ST_POSTTRIG);
    endfunction

endpackage

// File: rtl/sample_capture_ctrl_edge_detect.sv
// Rising-edge detector for the divided sample tick (same clock domain, so a
// single delay flop is enough).
module edge_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic tick_in,
    output logic tick_rise
);

    logic tick_q;
    logic tick_d;

    always_comb begin
        tick_d = tick_in;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_rise = tick_in & ~tick_q;

endmodule

// File: rtl/sample_capture_ctrl.sv
// Capture controller: streams ADC samples into a circular buffer with a
// programmable pre-trigger window and a level or forced trigger.
module sample_capture_ctrl
    import sample_capture_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic [ADDR_W-1:0] pretrig_len,
    output logic              run_flag,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] MAX_PRE   = '1;

    logic [2:0]        state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] plen_q, plen_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic              force_pend_q, force_pend_d;

    logic              tick_rise;
    logic              running;
    logic              level_hit;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   post_target;

    edge_detect u_edge_detect (
        .clock_in  (clock_in),
        .reset     (reset),
        .tick_in   (sample_tick),
        .tick_rise (tick_rise)
    );

    assign running     = is_run_state(state_q);
    assign cnt_inc     = cnt_q + CNT_ONE;
    assign post_target = DEPTH_CNT - {1'b0, plen_q};

    // The sample being written (wr_data_q) is compared against the one before it.
    assign level_hit = prev_vld_q &&
                       (trig_rising ? ((prev_q <  trig_level) && (wr_data_q >= trig_level))
                                    : ((prev_q >= trig_level) && (wr_data_q <  trig_level)));

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        trig_addr_d  = trig_addr_q;
        plen_d       = plen_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        force_pend_d = force_pend_q;

        if (wr_en_q) begin
            wr_addr_d  = wr_addr_q + ADDR_ONE;
            prev_d     = wr_data_q;
            prev_vld_d = 1'b1;
            cnt_d      = cnt_inc;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d      = ST_PRETRIG;
                    wr_addr_d    = '0;
                    cnt_d        = '0;
                    prev_vld_d   = 1'b0;
                    force_pend_d = 1'b0;
                    plen_d       = (pretrig_len > MAX_PRE) ? MAX_PRE : pretrig_len;
                end
            end
            ST_PRETRIG: begin
                if ((plen_q == '0) || (wr_en_q && (cnt_inc == {1'b0, plen_q}))) begin
                    state_d = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (force_trig) begin
                    force_pend_d = 1'b1;
                end
                if (wr_en_q && (force_trig || force_pend_q || level_hit)) begin
                    trig_addr_d  = wr_addr_q;
                    cnt_d        = CNT_ONE;
                    force_pend_d = 1'b0;
                    state_d      = (post_target == CNT_ONE) ? ST_DONE : ST_POSTTRIG;
                end
            end
            ST_POSTTRIG: begin
                if (wr_en_q && (cnt_inc == post_target)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A sample captured in the cycle the capture completes must not be written.
        wr_en_d = tick_rise && running && is_run_state(state_d);
        if (wr_en_d) begin
            wr_data_d = adc_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            trig_addr_q  <= '0;
            plen_q       <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            force_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            trig_addr_q  <= trig_addr_d;
            plen_q       <= plen_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            force_pend_q <= force_pend_d;
        end
    end

    assign run_flag  = running;
    assign busy      = running;
    assign done      = (state_q == ST_DONE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign trig_addr = trig_addr_q;

endmodule
